// File: rtl/multi_charger_controller.sv
// rtl/multi_charger_controller.sv - keypad purchase FSM feeding NUM_CH independent charge countdowns
module multi_charger_controller #(
    parameter int NUM_CH    = 2,
    parameter int MONEY_W   = 5,
    parameter int TIME_W    = 7,
    parameter int MAX_MONEY = 20,
    parameter int RATE      = 2,
    parameter int TICK_DIV  = 1000,
    parameter int IDLE_SEC  = 10,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               key_value,
    input  logic                     press,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     confirm,
    input  logic [CH_W-1:0]          ch_sel,
    output logic                     no_display,
    output logic [MONEY_W-1:0]       all_money,
    output logic [TIME_W-1:0]        remaining_time,
    output logic [NUM_CH*TIME_W-1:0] ch_time,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic [2:0]               current_state,
    output logic                     err
);

    localparam int TK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ID_W   = $clog2(IDLE_SEC + 1);
    localparam int PROD_W = MONEY_W + 4;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_READY = 3'd1,
        S_DIG1  = 3'd2,
        S_DIG2  = 3'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [MONEY_W-1:0]             money_q, money_d;
    logic [TIME_W-1:0]              rtime_q, rtime_d;
    logic                           nodisp_q, nodisp_d;
    logic                           err_q, err_d;
    logic [NUM_CH-1:0]              busy_q, busy_d;
    logic [NUM_CH-1:0][TIME_W-1:0]  chtime_q, chtime_d;
    logic [TK_W-1:0]                tick_cnt_q, tick_cnt_d;
    logic [ID_W-1:0]                idle_q, idle_d;
    logic                           start_q, clear_q, confirm_q, press_q;

    logic start_ev, clear_ev, confirm_ev, press_ev, any_ev;
    logic tick, key_ok, in_dig, sel_ok, sel_busy, commit;
    logic [PROD_W-1:0] prod;
    logic [MONEY_W-1:0] sat_money;
    logic [TIME_W-1:0] commit_time;

    assign start_ev   = start & ~start_q;
    assign clear_ev   = clear & ~clear_q;
    assign confirm_ev = confirm & ~confirm_q;
    assign press_ev   = press & ~press_q;
    assign any_ev     = start_ev | clear_ev | confirm_ev | press_ev;

    assign tick        = (tick_cnt_q == TK_W'(TICK_DIV - 1));
    assign tick_cnt_d  = tick ? '0 : tick_cnt_q + TK_W'(1);
    assign key_ok      = (key_value <= 4'd9);
    assign in_dig      = (state_q == S_DIG1) || (state_q == S_DIG2);
    assign sel_ok      = (int'(ch_sel) < NUM_CH);
    assign prod        = PROD_W'(money_q) * PROD_W'(10) + PROD_W'(key_value);
    assign sat_money   = (prod > PROD_W'(MAX_MONEY)) ? MONEY_W'(MAX_MONEY) : prod[MONEY_W-1:0];
    assign commit_time = TIME_W'(money_q * RATE);

    always_comb begin
        sel_busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) sel_busy = busy_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        money_d  = money_q;
        nodisp_d = nodisp_q;
        idle_d   = idle_q;
        err_d    = 1'b0;
        commit   = 1'b0;

        // One event per cycle: start > clear > confirm > press.
        if (start_ev) begin
            if (state_q == S_OFF) begin
                state_d  = S_READY;
                nodisp_d = 1'b0;
                money_d  = '0;
            end
        end else if (state_q != S_OFF) begin
            if (clear_ev) begin
                if (in_dig) begin
                    state_d = S_READY;
                    money_d = '0;
                end
            end else if (confirm_ev) begin
                if (in_dig) begin
                    if (sel_ok && !sel_busy && (money_q != '0)) begin
                        commit  = 1'b1;
                        state_d = S_READY;
                        money_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end else if (press_ev && key_ok) begin
                if (state_q == S_READY) begin
                    state_d = S_DIG1;
                    money_d = MONEY_W'(key_value);
                end else if (state_q == S_DIG1) begin
                    state_d = S_DIG2;
                    money_d = sat_money;
                end
            end
        end

        // Idle timer saturates while any outlet is charging so the display stays lit.
        if (state_q != S_OFF) begin
            if (any_ev) begin
                idle_d = '0;
            end else if (tick) begin
                idle_d = (idle_q == ID_W'(IDLE_SEC)) ? idle_q : idle_q + ID_W'(1);
                if ((idle_d == ID_W'(IDLE_SEC)) && (busy_q == '0)) begin
                    state_d  = S_OFF;
                    nodisp_d = 1'b1;
                    money_d  = '0;
                    idle_d   = '0;
                end
            end
        end

        rtime_d = TIME_W'(money_d * RATE);

        for (int i = 0; i < NUM_CH; i++) begin
            chtime_d[i] = chtime_q[i];
            if (tick && (chtime_q[i] != '0)) chtime_d[i] = chtime_q[i] - TIME_W'(1);
            if (commit && (ch_sel == CH_W'(i))) chtime_d[i] = commit_time;
            busy_d[i] = (chtime_d[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            money_q    <= '0;
            rtime_q    <= '0;
            nodisp_q   <= 1'b1;
            err_q      <= 1'b0;
            busy_q     <= '0;
            chtime_q   <= '0;
            tick_cnt_q <= '0;
            idle_q     <= '0;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            confirm_q  <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            money_q    <= money_d;
            rtime_q    <= rtime_d;
            nodisp_q   <= nodisp_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            chtime_q   <= chtime_d;
            tick_cnt_q <= tick_cnt_d;
            idle_q     <= idle_d;
            start_q    <= start;
            clear_q    <= clear;
            confirm_q  <= confirm;
            press_q    <= press;
        end
    end

    assign no_display     = nodisp_q;
    assign all_money      = money_q;
    assign remaining_time = rtime_q;
    assign ch_time        = chtime_q;
    assign ch_busy        = busy_q;
    assign current_state  = state_q;
    assign err            = err_q;

endmodule
